// File: rtl/imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl
//   Boot controller for a 64 x 32-bit instruction memory. On start it
//   optionally clears the memory, then packs loader bytes into 32-bit words
//   and writes them at ascending addresses. When the program is loaded it
//   releases the CPU and hands the memory address bus over to the fetch port.
//
// Configuration macro:
//   IMEM_BOOT_CLEAR_EN  defined   -> 64-cycle CLEAR pass before loading
//                       undefined -> start goes straight to LOAD; words not
//                                    loaded keep their previous contents
//
// Parameter:
//   BIG_ENDIAN  1: first byte of a word lands in [31:24]; 0: in [7:0]
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      single-cycle boot request (honoured in IDLE and RUN)
//   ld_valid_i   loader byte valid
//   ld_data_i    loader byte
//   ld_last_i    final byte of the program (qualified by ld_valid_i)
//   ld_ready_o   byte accepted this cycle when ld_valid_i is high
//   fetch_a_i    CPU fetch word address (routed to mem_a_o in RUN)
//   mem_a_o      instruction memory word address
//   mem_we_o     instruction memory write enable
//   mem_wd_o     instruction memory write data
//   cpu_rst_o    holds the CPU in reset outside RUN
//   busy_o       high in CLEAR or LOAD
//   done_o       one-cycle pulse in the first RUN cycle
//   ovf_o        sticky: program exceeded 64 words
//   word_cnt_o   words written in the current load (0..64)
// -----------------------------------------------------------------------------
module imem_boot_ctrl #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_data_i,
  input  logic        ld_last_i,
  output logic        ld_ready_o,
  input  logic [5:0]  fetch_a_i,
  output logic [5:0]  mem_a_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wd_o,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o,
  output logic [6:0]  word_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
`ifdef IMEM_BOOT_CLEAR_EN
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_BOOT  = S_CLEAR;
`else
  localparam logic [2:0] S_BOOT  = S_LOAD;
`endif

  logic [2:0]  state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shift_q, shift_d;
  logic [6:0]  word_cnt_q, word_cnt_d;
  logic        ovf_q, ovf_d;
  logic        last_q, last_d;   // word being written carried ld_last
  logic        done_q, done_d;
`ifdef IMEM_BOOT_CLEAR_EN
  logic [5:0]  clr_cnt_q, clr_cnt_d;
`endif

  logic [1:0]  ld_lane;
  logic        accept;

  // Byte lane that the current byte index fills; lanes not yet written stay
  // zero because the register is cleared at the start of every word.
  assign ld_lane = BIG_ENDIAN ? (2'd3 - byte_idx_q) : byte_idx_q;
  assign accept  = ld_valid_i && ld_ready_o;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    last_d     = last_q;
    done_d     = 1'b0;
`ifdef IMEM_BOOT_CLEAR_EN
    clr_cnt_d  = clr_cnt_q;
`endif
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start_i) begin
          state_d    = S_BOOT;
          byte_idx_d = 2'd0;
          shift_d    = 32'd0;
          word_cnt_d = 7'd0;
          ovf_d      = 1'b0;
          last_d     = 1'b0;
`ifdef IMEM_BOOT_CLEAR_EN
          clr_cnt_d  = 6'd0;
`endif
        end
      end
`ifdef IMEM_BOOT_CLEAR_EN
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 6'd1;
        if (clr_cnt_q == 6'd63) state_d = S_LOAD;
      end
`endif
      S_LOAD: begin
        if (accept) begin
          shift_d[{ld_lane, 3'b000} +: 8] = ld_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3 || ld_last_i) begin
            state_d = S_WRITE;
            last_d  = ld_last_i;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + 7'd1;
        byte_idx_d = 2'd0;
        shift_d    = 32'd0;
        last_d     = 1'b0;
        if (last_q) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end else if (word_cnt_q == 7'd63) begin
          // 64th word written and still no ld_last: program too large
          state_d = S_RUN;
          ovf_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      shift_q    <= 32'd0;
      word_cnt_q <= 7'd0;
      ovf_q      <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef IMEM_BOOT_CLEAR_EN
      clr_cnt_q  <= 6'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      last_q     <= last_d;
      done_q     <= done_d;
`ifdef IMEM_BOOT_CLEAR_EN
      clr_cnt_q  <= clr_cnt_d;
`endif
    end
  end

  // Memory port mux: fetch_a_i only reaches the memory in RUN.
  always_comb begin
    mem_a_o  = word_cnt_q[5:0];
    mem_we_o = 1'b0;
    mem_wd_o = 32'd0;
    case (state_q)
`ifdef IMEM_BOOT_CLEAR_EN
      S_CLEAR: begin
        mem_a_o  = clr_cnt_q;
        mem_we_o = 1'b1;
      end
`endif
      S_WRITE: begin
        mem_we_o = 1'b1;
        mem_wd_o = shift_q;
      end
      S_RUN:   mem_a_o = fetch_a_i;
      default: ;
    endcase
  end

  assign ld_ready_o = (state_q == S_LOAD);
  assign cpu_rst_o  = (state_q != S_RUN);
`ifdef IMEM_BOOT_CLEAR_EN
  assign busy_o     = (state_q == S_CLEAR) || (state_q == S_LOAD);
`else
  assign busy_o     = (state_q == S_LOAD);
`endif
  assign done_o     = done_q;
  assign ovf_o      = ovf_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_ctrl
//   Directed bench for imem_boot_ctrl. Two instances (big- and little-endian)
//   share one stimulus; a small write monitor per instance records memory
//   contents and the number of writes. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic [5:0]  fetch_a;

  logic        be_ready, be_we, be_cpu_rst, be_busy, be_done, be_ovf;
  logic [5:0]  be_a;
  logic [31:0] be_wd;
  logic [6:0]  be_cnt;
  logic        le_ready, le_we, le_cpu_rst, le_busy, le_done, le_ovf;
  logic [5:0]  le_a;
  logic [31:0] le_wd;
  logic [6:0]  le_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_be [64];
  logic [31:0] mem_le [64];
  int          wcnt_be = 0;
  int          wcnt_le = 0;

  always #5 clk = ~clk;

  imem_boot_ctrl #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(be_ready), .fetch_a_i(fetch_a),
    .mem_a_o(be_a), .mem_we_o(be_we), .mem_wd_o(be_wd),
    .cpu_rst_o(be_cpu_rst), .busy_o(be_busy), .done_o(be_done),
    .ovf_o(be_ovf), .word_cnt_o(be_cnt)
  );

  imem_boot_ctrl #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(le_ready), .fetch_a_i(fetch_a),
    .mem_a_o(le_a), .mem_we_o(le_we), .mem_wd_o(le_wd),
    .cpu_rst_o(le_cpu_rst), .busy_o(le_busy), .done_o(le_done),
    .ovf_o(le_ovf), .word_cnt_o(le_cnt)
  );

  // Write monitors: behave like the instruction memory each DUT drives.
  always @(posedge clk) begin
    if (be_we) begin
      mem_be[be_a] <= be_wd;
      wcnt_be      <= wcnt_be + 1;
    end
    if (le_we) begin
      mem_le[le_a] <= le_wd;
      wcnt_le      <= wcnt_le + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until the handshake completes.
  task automatic send_byte(input logic [7:0] d, input logic l);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = l;
    for (int k = 0; k < 20 && !be_ready; k++) tick();
    if (!be_ready) check("hs_timeout", {31'd0, be_ready}, 32'd1);
    else           tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Pulse start and follow the controller until LOAD accepts bytes.
  task automatic do_start();
    int w0;
    w0    = wcnt_be;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef IMEM_BOOT_CLEAR_EN
    check("clr_rdy", {31'd0, be_ready}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      check("clr_we", {31'd0, be_we}, 32'd1);
      check("clr_a",  {26'd0, be_a}, i);
      check("clr_wd", be_wd, 32'd0);
      start = (i == 10);   // must be ignored mid-clear
      tick();
      start = 1'b0;
    end
    check("clr_nwr", wcnt_be - w0, 32'd64);
`else
    check("boot_nwr", wcnt_be - w0, 32'd0);
`endif
    check("boot_rdy",  {31'd0, be_ready}, 32'd1);
    check("boot_busy", {31'd0, be_busy}, 32'd1);
    check("boot_cnt",  {25'd0, be_cnt}, 32'd0);
    check("boot_ovf",  {31'd0, be_ovf}, 32'd0);
    // start while loading must not restart anything
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ld_start_ign", {31'd0, be_ready}, 32'd1);
    check("ld_start_we",  {31'd0, be_we}, 32'd0);
  endtask

  initial begin
    int w0;
    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    ld_last = 1'b0; fetch_a = 6'd0;
    #2;
    check("rst_cpu",  {31'd0, be_cpu_rst}, 32'd1);
    check("rst_we",   {31'd0, be_we}, 32'd0);
    check("rst_rdy",  {31'd0, be_ready}, 32'd0);
    check("rst_busy", {31'd0, be_busy}, 32'd0);
    check("rst_done", {31'd0, be_done}, 32'd0);
    check("rst_ovf",  {31'd0, be_ovf}, 32'd0);
    check("rst_cnt",  {25'd0, be_cnt}, 32'd0);
    check("rst_a",    {26'd0, be_a}, 32'd0);
    check("rst_wd",   be_wd, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle_hold", {31'd0, be_cpu_rst}, 32'd1);

    // Single word 20 08 00 05, last on the 4th byte
    do_start();
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b1);
    check("w1_we",   {31'd0, be_we}, 32'd1);
    check("w1_a",    {26'd0, be_a}, 32'd0);
    check("w1_wd",   be_wd, 32'h20080005);
    check("w1_wdle", le_wd, 32'h05000820);
    check("w1_rdy",  {31'd0, be_ready}, 32'd0);
    tick();
    check("w1_done", {31'd0, be_done}, 32'd1);
    check("w1_cpu",  {31'd0, be_cpu_rst}, 32'd0);
    check("w1_cnt",  {25'd0, be_cnt}, 32'd1);
    check("w1_busy", {31'd0, be_busy}, 32'd0);
    check("w1_mem",  mem_be[0], 32'h20080005);
    tick();
    check("w1_done0", {31'd0, be_done}, 32'd0);
    check("w1_run",   {31'd0, be_cpu_rst}, 32'd0);
    fetch_a = 6'h15;
    #1;
    check("run_fetch",   {26'd0, be_a}, 32'h15);
    check("run_fetchle", {26'd0, le_a}, 32'h15);

    // Partial word AA BB, last on BB (zero-filled)
    do_start();
    check("rst_cpu_again", {31'd0, be_cpu_rst}, 32'd1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    check("p_we",   {31'd0, le_we}, 32'd1);
    check("p_a",    {26'd0, le_a}, 32'd0);
    check("p_wdle", le_wd, 32'h0000BBAA);
    check("p_wdbe", be_wd, 32'hAABB0000);
    tick();
    check("p_done", {31'd0, le_done}, 32'd1);
    check("p_cpu",  {31'd0, le_cpu_rst}, 32'd0);
    check("p_cnt",  {25'd0, le_cnt}, 32'd1);

    // Overflow: 256 bytes without ld_last
    do_start();
    w0 = wcnt_be;
    for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b0);
    tick();
    check("ovf_nwr",  wcnt_be - w0, 32'd64);
    check("ovf_flag", {31'd0, be_ovf}, 32'd1);
    check("ovf_done", {31'd0, be_done}, 32'd1);
    check("ovf_cpu",  {31'd0, be_cpu_rst}, 32'd0);
    check("ovf_cnt",  {25'd0, be_cnt}, 32'd64);
    check("ovf_m0",   mem_be[0], 32'h00010203);
    check("ovf_m63",  mem_be[63], 32'hFCFDFEFF);
    check("ovf_m63le", mem_le[63], 32'hFFFEFDFC);
    ld_valid = 1'b1;
    ld_data  = 8'h99;
    for (int i = 0; i < 4; i++) begin
      check("ovf_rdy", {31'd0, be_ready}, 32'd0);
      tick();
    end
    ld_valid = 1'b0;
    check("ovf_nwr2", wcnt_be - w0, 32'd64);
    check("ovf_sticky", {31'd0, be_ovf}, 32'd1);
    fetch_a = 6'h2A;
    #1;
    check("ovf_fetch", {26'd0, be_a}, 32'h2A);

    // Asynchronous reset while in RUN with ovf set
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ovf",  {31'd0, be_ovf}, 32'd0);
    check("arst_cnt",  {25'd0, be_cnt}, 32'd0);
    check("arst_cpu",  {31'd0, be_cpu_rst}, 32'd1);
    check("arst_a",    {26'd0, be_a}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset during LOAD after two bytes of the second word
    do_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    check("lat_we",   {31'd0, be_we}, 32'd1);
    check("lat_wd",   be_wd, 32'h11223344);
    check("lat_wdle", le_wd, 32'h44332211);
    check("lat_rdy",  {31'd0, be_ready}, 32'd0);
    tick();
    check("lat_rdy2", {31'd0, be_ready}, 32'd1);
    check("lat_cnt",  {25'd0, be_cnt}, 32'd1);
    check("lat_a",    {26'd0, be_a}, 32'd1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("lrst_rdy",  {31'd0, be_ready}, 32'd0);
    check("lrst_busy", {31'd0, be_busy}, 32'd0);
    check("lrst_cpu",  {31'd0, be_cpu_rst}, 32'd1);
    check("lrst_cnt",  {25'd0, be_cnt}, 32'd0);
    check("lrst_we",   {31'd0, be_we}, 32'd0);
    check("lrst_a",    {26'd0, be_a}, 32'd0);
    check("lrst_done", {31'd0, be_done}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("noresume_rdy",  {31'd0, be_ready}, 32'd0);
    check("noresume_busy", {31'd0, be_busy}, 32'd0);
    check("noresume_cpu",  {31'd0, be_cpu_rst}, 32'd1);
    do_start();
    send_byte(8'h77, 1'b1);
    check("post_wd",   be_wd, 32'h77000000);
    check("post_wdle", le_wd, 32'h00000077);
    check("post_a",    {26'd0, be_a}, 32'd0);
    tick();
    check("post_done", {31'd0, be_done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
